scan_select: RTL and testbench
==============================

Name: scan_select

Overview:
Parametrised time-multiplexed channel scanner. It is the successor to the fixed 2-bit-to-4-line enable decoder and generates its own scan index from an internal prescaler. It drives one-hot select lines to tri-state buffer enables or multiplexed display digits, and adds three things the fixed decoder lacks: a per-channel skip mask, dead-time blanking between channels, and a hold mode.

Parameters:
N_CH, 4, number of channels / select lines (>=2)
DIV, 50000, clock cycles per channel slot (>=2)
BLANK, 2, dead-time cycles at the start of each slot with all selects inactive (0 <= BLANK < DIV)
SEL_ACTIVE_LOW, 0, 1 = invert sel outputs (inactive level becomes all-ones)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  scan enable
hold  input  1  freeze prescaler and index
mask  input  N_CH  channel enable mask; mask[k]=1 means channel k is scanned
sel  output  N_CH  one-hot select; channel k drives sel[N_CH-1-k]
idx  output  clog2(N_CH)  current channel index
blank  output  1  1 when all selects are inactive
step  output  1  one-cycle pulse on each slot advance

Behaviour:
- One clock and one synchronous active-high reset. All outputs are registered.
- Internal state: prescaler pre (0..DIV-1) and index idx.
- Reset values: pre=0, idx=0, sel=inactive (all 0, or all 1 if SEL_ACTIVE_LOW), blank=1, step=0. Reset takes priority over every other input, including mid-slot.
- Each edge with en=1 and hold=0:
  - If pre==DIV-1: pre<=0, idx<=next enabled channel, step<=1.
  - Otherwise: pre<=pre+1, step<=0.
- Next enabled channel: the first j in cyclic order idx+1, idx+2, ..., wrapping N_CH-1 to 0, with mask[j]=1.
  - If the only set bit is idx itself, idx is unchanged.
  - If mask==0, idx is unchanged.
  - step still pulses in both cases.
- Outputs on each edge are computed from the next-state pre/idx and the current en/mask:
  - active = en & mask[idx_next] & (pre_next >= BLANK)
  - sel = one-hot of idx_next if active, else inactive
  - blank = ~active
- Resulting slot shape: BLANK cycles blank, then DIV-BLANK cycles selected.
- en=0: pre<=0, idx held, sel inactive, blank=1, step=0. On re-enable, the slot restarts at the same idx, beginning with blanking.
- hold=1 (with en=1): pre and idx frozen, step=0, sel/blank keep their current values. hold is ignored when en=0.
- mask change: takes effect on the next edge. If mask[idx] is cleared mid-slot, sel goes inactive at once and the advance still occurs at slot end.
- Guarantees:
  - sel never has more than one active bit.
  - sel is never active in the cycle of and after an idx change until BLANK cycles have elapsed (no overlap between channels).
- Width rules:
  - idx width is clog2(N_CH).
  - pre width is clog2(DIV).
  - Wrap for non-power-of-two N_CH is explicit (N_CH-1 goes to 0). idx never holds a value >= N_CH.

Test Plan:
1. Reset: assert rst for 2 cycles with en=1, mask=1111 -> sel=0000, blank=1, idx=0, step=0. Apply rst again mid-slot -> same values on the next edge.
2. Basic scan, N_CH=4, DIV=4, BLANK=1, mask=1111, en=1:
   - per slot, sel = 0000 then 3 cycles of 1000; then 0000 then 3 cycles of 0100; then 0010; then 0001; then back to 1000.
   - step pulses every 4 cycles; idx runs 0,1,2,3,0.
3. Skip mask=1010 (channels 1 and 3) from reset:
   - slot 0 is fully blank.
   - idx then runs 1,3,1,3 with sel 0100 and 0001 respectively.
   - No cycle shows 1000 or 0010.
4. mask=0000: sel stays 0000 and blank=1 for 20 cycles; idx stays 0; step still pulses every DIV cycles.
5. Drop en in cycle 2 of the idx=2 slot:
   - next edge: sel=0000, blank=1, step=0.
   - re-enable: blank for BLANK cycles, then sel=0010 for DIV-BLANK cycles.
6. Assert hold for 10 cycles mid-slot -> idx, sel and blank unchanged and step=0; the slot then completes its remaining cycles. Repeat with SEL_ACTIVE_LOW=1 -> idle sel=1111 and the idx=1 select reads 1011.

Source files
------------

// File: rtl/scan_select.sv
// Time-multiplexed channel scanner: prescaled slot timer, masked round-robin
// index, dead-time blanking at slot start, and a hold mode that freezes everything.
module scan_select #(
  parameter int N_CH           = 4,
  parameter int DIV            = 50000,
  parameter int BLANK          = 2,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hold,
  input  logic [N_CH-1:0]         mask,
  output logic [N_CH-1:0]         sel,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    blank,
  output logic                    step
);

  localparam int IW = $clog2(N_CH);
  localparam int PW = $clog2(DIV);

  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]   BLANK_W  = PW'(BLANK);
  localparam logic [IW-1:0]   IDX_LAST = IW'(N_CH - 1);
  localparam logic [N_CH-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_CH-1:0] CH0_BIT  = {1'b1, {(N_CH-1){1'b0}}};

  logic [PW-1:0]   pre_q;
  logic [PW-1:0]   pre_n;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_adv;
  logic [IW-1:0]   idx_n;
  logic [IW-1:0]   cand;
  logic            found;
  logic            wrap;
  logic            active;
  logic [N_CH-1:0] sel_n;

  // Search idx+1 .. idx+N_CH-1 cyclically; fall back to idx when nothing else is enabled.
  always_comb begin
    idx_adv = idx_q;
    found   = 1'b0;
    cand    = idx_q;
    for (int unsigned off = 1; off < N_CH; off++) begin
      cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
      if (!found && mask[cand]) begin
        idx_adv = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    wrap   = (pre_q == PRE_LAST);
    pre_n  = wrap ? '0 : pre_q + 1'b1;
    idx_n  = wrap ? idx_adv : idx_q;
    active = mask[idx_n] && (pre_n >= BLANK_W);
    // Channel 0 owns the MSB of sel; polarity applied by XOR with the idle level.
    sel_n  = (active ? (CH0_BIT >> idx_n) : '0) ^ SEL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      sel   <= SEL_IDLE;
      blank <= 1'b1;
      step  <= 1'b0;
    end else if (!en) begin
      pre_q <= '0;
      sel   <= SEL_IDLE;
      blank <= 1'b1;
      step  <= 1'b0;
    end else if (hold) begin
      step  <= 1'b0;
    end else begin
      pre_q <= pre_n;
      idx_q <= idx_n;
      sel   <= sel_n;
      blank <= !active;
      step  <= wrap;
    end
  end

  assign idx = idx_q;

endmodule

// File: tb/tb_scan_select.sv
// Scoreboard bench for scan_select: three configurations share one stimulus stream
// and are compared every cycle against a slot/channel reference model.
module tb_scan_select;

  localparam int NI = 3;
  localparam int PN [NI] = '{4, 4, 3};
  localparam int PD [NI] = '{4, 5, 3};
  localparam int PB [NI] = '{1, 2, 1};
  localparam int PA [NI] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst, en, hold;
  logic [3:0] mask;

  logic [3:0] sel0, sel1;
  logic [2:0] sel2;
  logic [1:0] idx0, idx1, idx2;
  logic       blank0, blank1, blank2;
  logic       step0, step1, step2;

  always #5 clk = ~clk;

  scan_select #(.N_CH(4), .DIV(4), .BLANK(1), .SEL_ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .mask(mask),
    .sel(sel0), .idx(idx0), .blank(blank0), .step(step0));

  scan_select #(.N_CH(4), .DIV(5), .BLANK(2), .SEL_ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .mask(mask),
    .sel(sel1), .idx(idx1), .blank(blank1), .step(step1));

  scan_select #(.N_CH(3), .DIV(3), .BLANK(1), .SEL_ACTIVE_LOW(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .mask(mask[2:0]),
    .sel(sel2), .idx(idx2), .blank(blank2), .step(step2));

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       blank;
    logic       step;
  } exp_t;
  typedef exp_t [NI-1:0] exp_vec_t;

  exp_vec_t sbq[$];
  int errors = 0;
  int checks = 0;

  // Reference model: position within slot, current channel, last driven outputs.
  int pre_m   [NI];
  int ch_m    [NI];
  int sel_m   [NI];
  bit blank_m [NI];

  task automatic model_step(input bit r, input bit e, input bit h, input logic [3:0] m);
    exp_vec_t ev;
    int n, idle, nc;
    bit stp, act;
    for (int i = 0; i < NI; i++) begin
      n    = PN[i];
      idle = (PA[i] != 0) ? (1 << n) - 1 : 0;
      stp  = 1'b0;
      if (r) begin
        pre_m[i] = 0; ch_m[i] = 0; sel_m[i] = idle; blank_m[i] = 1'b1;
      end else if (!e) begin
        pre_m[i] = 0; sel_m[i] = idle; blank_m[i] = 1'b1;
      end else if (!h) begin
        if (pre_m[i] == PD[i] - 1) begin
          pre_m[i] = 0;
          stp      = 1'b1;
          nc       = ch_m[i];
          for (int o = 1; o < n; o++) begin
            if (((int'(m) >> ((ch_m[i] + o) % n)) & 1) != 0) begin
              nc = (ch_m[i] + o) % n;
              break;
            end
          end
          ch_m[i] = nc;
        end else begin
          pre_m[i] = pre_m[i] + 1;
        end
        act        = (((int'(m) >> ch_m[i]) & 1) != 0) && (pre_m[i] >= PB[i]);
        sel_m[i]   = (act ? (1 << (n - 1 - ch_m[i])) : 0) ^ idle;
        blank_m[i] = !act;
      end
      ev[i].sel   = 4'(sel_m[i]);
      ev[i].idx   = 2'(ch_m[i]);
      ev[i].blank = blank_m[i];
      ev[i].step  = stp;
    end
    sbq.push_back(ev);
  endtask

  task automatic tick(input bit r, input bit e, input bit h, input logic [3:0] m);
    rst  = r;
    en   = e;
    hold = h;
    mask = m;
    model_step(r, e, h, m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_vec_t ex, ac;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        ex    = sbq.pop_front();
        ac[0] = {sel0, idx0, blank0, step0};
        ac[1] = {sel1, idx1, blank1, step1};
        ac[2] = {1'b0, sel2, idx2, blank2, step2};
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (ac[i] !== ex[i]) begin
            errors++;
            $display("FAIL inst%0d t=%0t: got sel=%b idx=%0d blank=%b step=%b, expected sel=%b idx=%0d blank=%b step=%b",
                     i, $time, ac[i].sel, ac[i].idx, ac[i].blank, ac[i].step,
                     ex[i].sel, ex[i].idx, ex[i].blank, ex[i].step);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] m;
    int guard;
    rst = 1'b1; en = 1'b1; hold = 1'b0; mask = 4'hf;

    tick(1, 1, 0, 4'hf);
    tick(1, 1, 0, 4'hf);
    repeat (6) tick(0, 1, 0, 4'hf);
    tick(1, 1, 0, 4'hf);
    repeat (40) tick(0, 1, 0, 4'hf);

    tick(1, 1, 0, 4'hf);
    repeat (40) tick(0, 1, 0, 4'b1010);

    tick(1, 1, 0, 4'hf);
    repeat (20) tick(0, 1, 0, 4'h0);

    guard = 0;
    while (!(ch_m[0] == 2 && pre_m[0] == 2) && guard < 64) begin
      tick(0, 1, 0, 4'hf);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL en_drop_setup: got no idx=2 pre=2 point within %0d cycles, required one", guard);
    end
    repeat (3) tick(0, 0, 0, 4'hf);
    repeat (10) tick(0, 1, 0, 4'hf);

    tick(0, 1, 0, 4'hf);
    repeat (10) tick(0, 1, 1, 4'hf);
    repeat (12) tick(0, 1, 0, 4'hf);

    m = 4'hf;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) m = 4'($urandom);
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 9) == 0, m);
    end

    repeat (3) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
